// File: rtl/video_scanline_fx_if.sv
// ---------------------------------------------------------------------------
// video_scanline_fx_if
//  Parallel RGB888 video stream with active-high timing strobes. One
//  instance carries the scaled stream into video_scanline_fx and a second
//  carries the processed stream out towards the HDMI encoder.
//
//  Signals
//   r, g, b    8 bits each   pixel colour channels
//   hs, vs, de 1 bit each    horizontal sync, vertical sync, data enable
//
//  Modports
//   master     drives the stream (producer side)
//   slave      receives the stream (consumer side)
// ---------------------------------------------------------------------------
interface video_scanline_fx_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;

    modport master (output r, g, b, hs, vs, de);
    modport slave  (input  r, g, b, hs, vs, de);
endinterface

// File: rtl/video_scanline_fx.sv
// ---------------------------------------------------------------------------
// video_scanline_fx
//  CRT scanline effect placed behind the 3x video scaler. Every SCALE-line
//  group has one line (phase DARK_LINE) darkened by the intensity latched at
//  the start of the frame. Pixels beyond ACTIVE_W in a line, and lines beyond
//  ACTIVE_H in a frame, are forced to black. The timing strobes are delayed
//  by the same two register stages as the pixel and are never altered.
//
//  Parameters
//   SCALE      output lines per native line (line-phase modulus, >= 2)
//   DARK_LINE  line phase that gets darkened (0..SCALE-1)
//   ACTIVE_W   max active pixels per line
//   ACTIVE_H   max active lines per frame
//
//  Ports
//   clk        video clock, rising edge
//   rst        synchronous reset, active-high
//   level      scanline intensity: 0 off, 1 25%, 2 50%, 3 75% darker
//   vid_in     scaled RGB + HS/VS/DE stream (slave)
//   vid_out    processed RGB + HS/VS/DE stream, 2 clk later (master)
//
//  Configuration
//   SCANLINE_ALT_PHASE_EN  when defined, a frame-parity bit toggles on every
//                          VS rising edge and odd frames darken phase
//                          (DARK_LINE+1)%SCALE instead of DARK_LINE.
// ---------------------------------------------------------------------------
module video_scanline_fx #(
    parameter int SCALE     = 3,
    parameter int DARK_LINE = 2,
    parameter int ACTIVE_W  = 960,
    parameter int ACTIVE_H  = 672
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 level,
    video_scanline_fx_if.slave         vid_in,
    video_scanline_fx_if.master        vid_out
);

    localparam int XW = $clog2(ACTIVE_W + 1);
    localparam int YW = $clog2(ACTIVE_H + 1);
    localparam int PW = $clog2(SCALE);

    localparam logic [XW-1:0] X_MAX   = XW'(ACTIVE_W);
    localparam logic [YW-1:0] Y_MAX   = YW'(ACTIVE_H);
    localparam logic [PW-1:0] PH_LAST = PW'(SCALE - 1);
    localparam logic [PW-1:0] PH_DARK = PW'(DARK_LINE);
`ifdef SCANLINE_ALT_PHASE_EN
    localparam logic [PW-1:0] PH_ALT  = PW'((DARK_LINE + 1) % SCALE);
`endif

    // line/frame position and the per-frame intensity
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [PW-1:0] phase;
    logic [1:0]    lvl;

    // stage 1 registers
    logic [7:0]    s1_r;
    logic [7:0]    s1_g;
    logic [7:0]    s1_b;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_de;
    logic          s1_dark;
    logic          s1_blank;
    logic [1:0]    s1_lvl;

    // stage 2 (output) registers
    logic [7:0]    o_r;
    logic [7:0]    o_g;
    logic [7:0]    o_b;
    logic          o_hs;
    logic          o_vs;
    logic          o_de;

    logic          vs_rise;
    logic          de_fall;
    logic [PW-1:0] dark_phase;
    logic          dark_now;
    logic          blank_now;

    // The stage-1 copies of vs/de double as the "previous" samples for
    // edge detection, so a rising/falling edge is seen on the same cycle the
    // edge arrives at the input.
    assign vs_rise = vid_in.vs & ~s1_vs;
    assign de_fall = ~vid_in.de & s1_de;

`ifdef SCANLINE_ALT_PHASE_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (vs_rise) begin
            parity <= ~parity;
        end
    end

    assign dark_phase = parity ? PH_ALT : PH_DARK;
`else
    assign dark_phase = PH_DARK;
`endif

    // The incoming pixel is judged against the counters as they stand
    // before this cycle's update, so the first pixel of a line sees x = 0.
    assign dark_now  = (phase == dark_phase) && (lvl != 2'd0);
    assign blank_now = (x_cnt >= X_MAX) || (y_cnt >= Y_MAX);

    // Position counters. VS rising restarts the frame and is the only point
    // where the intensity is taken from the port; it also overrides a DE
    // falling edge landing on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
            phase <= '0;
            lvl   <= 2'd0;
        end else if (vs_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
            phase <= '0;
            lvl   <= level;
        end else if (de_fall) begin
            x_cnt <= '0;
            if (y_cnt != Y_MAX) begin
                y_cnt <= y_cnt + 1'b1;
            end
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end else if (vid_in.de && (x_cnt != X_MAX)) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    // Stage 1: capture the input together with its darken/blank decision.
    // The intensity travels with the pixel so a level latched on the next
    // VS cannot reach a pixel already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r     <= 8'd0;
            s1_g     <= 8'd0;
            s1_b     <= 8'd0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
            s1_dark  <= 1'b0;
            s1_blank <= 1'b0;
            s1_lvl   <= 2'd0;
        end else begin
            s1_r     <= vid_in.r;
            s1_g     <= vid_in.g;
            s1_b     <= vid_in.b;
            s1_hs    <= vid_in.hs;
            s1_vs    <= vid_in.vs;
            s1_de    <= vid_in.de;
            s1_dark  <= dark_now;
            s1_blank <= blank_now;
            s1_lvl   <= lvl;
        end
    end

    function automatic logic [7:0] shade(input logic [7:0] c,
                                         input logic       dark,
                                         input logic       blank,
                                         input logic       de,
                                         input logic [1:0] lv);
        logic [7:0] res;
        res = c;
        if (blank || !de) begin
            res = 8'd0;
        end else if (dark) begin
            case (lv)
                2'd1:    res = c - (c >> 2);
                2'd2:    res = c >> 1;
                2'd3:    res = c >> 2;
                default: res = c;
            endcase
        end
        return res;
    endfunction

    // Stage 2: apply the effect; timing strobes pass through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r  <= 8'd0;
            o_g  <= 8'd0;
            o_b  <= 8'd0;
            o_hs <= 1'b0;
            o_vs <= 1'b0;
            o_de <= 1'b0;
        end else begin
            o_r  <= shade(s1_r, s1_dark, s1_blank, s1_de, s1_lvl);
            o_g  <= shade(s1_g, s1_dark, s1_blank, s1_de, s1_lvl);
            o_b  <= shade(s1_b, s1_dark, s1_blank, s1_de, s1_lvl);
            o_hs <= s1_hs;
            o_vs <= s1_vs;
            o_de <= s1_de;
        end
    end

    assign vid_out.r  = o_r;
    assign vid_out.g  = o_g;
    assign vid_out.b  = o_b;
    assign vid_out.hs = o_hs;
    assign vid_out.vs = o_vs;
    assign vid_out.de = o_de;

endmodule
